cont_flag_datapath: RTL and testbench
=====================================

// Module: cont_flag_datapath
// PURPOSE
//   Datapath end of the controller interface: executes the 5-bit control-point word cp
//     from the one-hot controller each clock.
//   Returns registered status flags V (signed overflow) and Z (zero), which the controller
//     uses to select its next state.
//   Holds operand register A, accumulator R, and a wrapping step counter C.
//   Sits between the controller and the external data source din.
// PARAMETERS
//   WIDTH   8   data width of din, A, R and the ALU (two's complement)
//   CNT_W   4   width of step counter C
// PORTS
//   clk     in   1        system clock, all state updates on rising edge
//   clr     in   1        asynchronous, active-low reset (clears everything while low)
//   start   in   1        synchronous restart; same meaning as the controller's start
//   cp      in   5        control-point word from controller (bit meanings below)
//   din     in   WIDTH    operand data, sampled when cp[4]=1
//   V       out  1        registered signed-overflow flag to controller
//   Z       out  1        registered zero flag to controller
//   r_out   out  WIDTH    accumulator R (direct register output)
//   c_out   out  CNT_W    step counter C (direct register output)
//   wrap    out  1        one-cycle pulse: C wrapped from all-ones to 0
// BEHAVIOUR
//   Reset: clr=0 clears immediately, asynchronously, regardless of clk:
//     A=0, R=0, C=0, V=0, Z=0, wrap=0. Mid-operation reset discards all state.
//   Priority per rising edge: clr low > start=1 > cp actions.
//   start=1 (clr high): R=0, C=0, V=0, Z=0, wrap=0; A holds; cp ignored that cycle.
//   cp bit map (bits are independent; any combination is legal):
//     cp[4] LDA  A <= din
//     cp[3] SUB  ALU op: 0 -> alu = R + A, 1 -> alu = R - A (WIDTH bits, carry dropped)
//     cp[2] LDR  R <= alu
//     cp[1] INC  C <= C + 1, mod 2^CNT_W
//     cp[0] FLG  V <= signed overflow of alu; Z <= (alu == 0)
//   ALU: combinational from the current (pre-edge) R and A.
//     Same-cycle LDA+LDR: R takes the sum/difference with the OLD A.
//   Overflow rules:
//     add: V=1 iff R[msb]==A[msb] and alu[msb]!=R[msb]
//     sub: V=1 iff R[msb]!=A[msb] and alu[msb]!=R[msb]
//   FLG without LDR: flags reflect alu; R is unchanged.
//   LDR without FLG: V and Z hold their previous values.
//   wrap: 1 for exactly the cycle after an INC edge where C was all-ones; 0 otherwise.
//     start or clr clears it.
//   cp = 5'b00000: all registers hold; wrap goes to 0.
//   Latency: flags/R/C are visible 1 clk after the edge that executes cp.
//     The controller samples V,Z at the following edge, so cp at edge n steers the state
//     at edge n+1.
//   Controller codes decode naturally:
//     A=00110 -> LDR+INC, add
//     D=11001 -> LDA+SUB+FLG
//     F=01000 -> SUB only, no state change
//   No X propagation: unknown cp after reset is not a supported case; the bench drives cp
//     from reset.
// TESTING (WIDTH=8, CNT_W=4 unless noted)
//   1 clr=0 asserted between clock edges, mid-sequence with R=0x33, C=5
//     -> A,R,C,V,Z,wrap all 0 before the next clk edge.
//   2 start=1, then cp=10000 din=0x05, then cp=00100, then cp=00001
//     -> A=0x05, R=0x05, V=0, Z=0.
//   3 R=0x7F, A=0x01, cp=00101 -> R=0x80, V=1, Z=0.
//     Then A=0x01, cp=01001 (R=0x80) -> R unchanged 0x80, V=1, Z=0.
//   4 R=0x05, A=0x05, cp=01101 -> R=0x00, Z=1, V=0.
//     Next cp=00100 -> R=0x05, Z stays 1.
//   5 R=0x01, A=0x05, cp=10100 din=0x09 -> R=0x06 (old A used), A=0x09.
//   6 CNT_W=3: 8 consecutive cp=00010 from C=0 -> C counts 1..7,0.
//     wrap=1 only in the cycle C becomes 0.
//     start=1 during INC -> C=0, wrap=0.

Source files
------------

// File: rtl/cont_flag_datapath.sv
// Datapath side of the controller interface. Each clock it executes the
// 5-bit control-point word cp from the one-hot controller and returns the
// registered status flags V (signed overflow) and Z (zero).
// State held here: operand A, accumulator R, and a wrapping step counter C.
module cont_flag_datapath #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [4:0]       cp,
  input  logic [WIDTH-1:0] din,
  output logic             V,
  output logic             Z,
  output logic [WIDTH-1:0] r_out,
  output logic [CNT_W-1:0] c_out,
  output logic             wrap
);

  localparam int MSB = WIDTH - 1;

  // Control-point decode: the bits are independent, so any mix may be active.
  logic lda, sub, ldr, inc, flg;
  assign {lda, sub, ldr, inc, flg} = cp;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] alu;
  logic [CNT_W-1:0] c_reg;
  logic             v_reg;
  logic             z_reg;
  logic             wrap_reg;
  logic             ovf;
  logic             c_full;

  // ALU works on the pre-edge R and A. A same-cycle LDA therefore does not
  // affect what LDR writes into R. Carry out is dropped.
  always_comb begin
    alu = sub ? (r_reg - a_reg) : (r_reg + a_reg);
    if (sub)
      ovf = (r_reg[MSB] != a_reg[MSB]) && (alu[MSB] != r_reg[MSB]);
    else
      ovf = (r_reg[MSB] == a_reg[MSB]) && (alu[MSB] != r_reg[MSB]);
  end

  assign c_full = &c_reg;

  // Operand register: only the async clear resets it; start leaves A alone.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      a_reg <= '0;
    else if (!start && lda)
      a_reg <= din;
  end

  // Accumulator: loaded from the ALU on LDR, zeroed by start.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      r_reg <= '0;
    else if (start)
      r_reg <= '0;
    else if (ldr)
      r_reg <= alu;
  end

  // Step counter and its wrap pulse. The pulse marks the cycle after an INC
  // that rolled C from all-ones back to zero, and drops on every other edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      c_reg    <= '0;
      wrap_reg <= 1'b0;
    end else if (start) begin
      c_reg    <= '0;
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= inc && c_full;
      if (inc)
        c_reg <= c_reg + 1'b1;
    end
  end

  // Status flags: updated only on FLG, so an LDR alone leaves them as they were.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      v_reg <= 1'b0;
      z_reg <= 1'b0;
    end else if (start) begin
      v_reg <= 1'b0;
      z_reg <= 1'b0;
    end else if (flg) begin
      v_reg <= ovf;
      z_reg <= (alu == '0);
    end
  end

  assign V     = v_reg;
  assign Z     = z_reg;
  assign r_out = r_reg;
  assign c_out = c_reg;
  assign wrap  = wrap_reg;

endmodule

// File: tb/tb_cont_flag_datapath.sv
// Bench for cont_flag_datapath: a WIDTH=8/CNT_W=4 instance and a CNT_W=3
// instance run side by side against an arithmetic reference model.
module tb_cont_flag_datapath;

  logic       clk;
  logic       clr;
  logic       start0, start1;
  logic [4:0] cp0, cp1;
  logic [7:0] din0, din1;
  logic       v0, z0, wrap0, v1, z1, wrap1;
  logic [7:0] r0, r1;
  logic [3:0] c0;
  logic [2:0] c1;

  cont_flag_datapath #(.WIDTH(8), .CNT_W(4)) dut0 (
    .clk(clk), .clr(clr), .start(start0), .cp(cp0), .din(din0),
    .V(v0), .Z(z0), .r_out(r0), .c_out(c0), .wrap(wrap0)
  );

  cont_flag_datapath #(.WIDTH(8), .CNT_W(3)) dut1 (
    .clk(clk), .clr(clr), .start(start1), .cp(cp1), .din(din1),
    .V(v1), .Z(z1), .r_out(r1), .c_out(c1), .wrap(wrap1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int nstep = 0;

  // Reference state; index 0 = 4-bit counter instance, 1 = 3-bit counter instance
  int m_a[2], m_r[2], m_c[2], m_v[2], m_z[2], m_w[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_a[k] = 0; m_r[k] = 0; m_c[k] = 0; m_v[k] = 0; m_z[k] = 0; m_w[k] = 0;
    end
  endtask

  // One clock edge of the behavioural model: signed arithmetic on integers.
  task automatic model_edge(input int k, input logic st, input logic [4:0] cp, input logic [7:0] d);
    int sr, sa, res, alu, cmod;
    cmod = (k == 0) ? 16 : 8;
    if (st) begin
      m_r[k] = 0; m_c[k] = 0; m_v[k] = 0; m_z[k] = 0; m_w[k] = 0;
    end else begin
      sr  = (m_r[k] >= 128) ? m_r[k] - 256 : m_r[k];
      sa  = (m_a[k] >= 128) ? m_a[k] - 256 : m_a[k];
      res = cp[3] ? sr - sa : sr + sa;
      alu = (res + 512) % 256;
      if (cp[4]) m_a[k] = int'(d);
      if (cp[2]) m_r[k] = alu;
      m_w[k] = (cp[1] && m_c[k] == cmod - 1) ? 1 : 0;
      if (cp[1]) m_c[k] = (m_c[k] + 1) % cmod;
      if (cp[0]) begin
        m_v[k] = (res > 127 || res < -128) ? 1 : 0;
        m_z[k] = (alu == 0) ? 1 : 0;
      end
    end
  endtask

  task automatic check_all(input string name);
    check({name, ".r0"},    32'(r0),    32'(m_r[0]));
    check({name, ".c0"},    32'(c0),    32'(m_c[0]));
    check({name, ".v0"},    32'(v0),    32'(m_v[0]));
    check({name, ".z0"},    32'(z0),    32'(m_z[0]));
    check({name, ".wrap0"}, 32'(wrap0), 32'(m_w[0]));
    check({name, ".r1"},    32'(r1),    32'(m_r[1]));
    check({name, ".c1"},    32'(c1),    32'(m_c[1]));
    check({name, ".v1"},    32'(v1),    32'(m_v[1]));
    check({name, ".z1"},    32'(z1),    32'(m_z[1]));
    check({name, ".wrap1"}, 32'(wrap1), 32'(m_w[1]));
  endtask

  // Drive both instances for one edge, advance the model, check 1ns after the edge.
  task automatic step(input logic s0, input logic [4:0] p0, input logic [7:0] d0,
                      input logic s1, input logic [4:0] p1, input logic [7:0] d1);
    start0 = s0; cp0 = p0; din0 = d0;
    start1 = s1; cp1 = p1; din1 = d1;
    @(posedge clk);
    #1;
    model_edge(0, s0, p0, d0);
    model_edge(1, s1, p1, d1);
    nstep++;
    $display("step %0d: s=%0b cp=%05b din=%02h | s=%0b cp=%05b -> r=%02h c=%0h V=%0b Z=%0b w=%0b | c3=%0h w3=%0b",
             nstep, s0, p0, d0, s1, p1, r0, c0, v0, z0, wrap0, c1, wrap1);
    check_all($sformatf("step%0d", nstep));
  endtask

  // Main-instance step; the small instance idles on cp=0.
  task automatic op(input logic s, input logic [4:0] p, input logic [7:0] d);
    step(s, p, d, 1'b0, 5'b00000, 8'h00);
  endtask

  // Pull clr low between edges and check everything cleared before the next edge.
  task automatic async_clear();
    #3;
    clr = 1'b0;
    model_clear();
    #2;
    $display("async clear at %0t", $time);
    check_all("async_clr");
    #1;
    clr = 1'b1;
  endtask

  initial begin
    clr = 1'b0;
    start0 = 1'b0; cp0 = 5'b0; din0 = 8'h0;
    start1 = 1'b0; cp1 = 5'b0; din1 = 8'h0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #3;
    clr = 1'b1;

    // Mid-sequence async clear with R=0x33, C=5
    op(1'b1, 5'b00000, 8'h00);
    op(1'b0, 5'b10000, 8'h11);
    repeat (3) op(1'b0, 5'b00110, 8'h00);
    repeat (2) op(1'b0, 5'b00010, 8'h00);
    check("pre_clr.r", 32'(r0), 32'h33);
    check("pre_clr.c", 32'(c0), 32'h5);
    async_clear();
    // A must also be zero: R+A from R=0 stays 0 and flags Z
    op(1'b0, 5'b00101, 8'h00);
    check("a_cleared.z", 32'(z0), 32'h1);

    // Load A, copy to R, flag
    op(1'b1, 5'b00000, 8'h00);
    op(1'b0, 5'b10000, 8'h05);
    op(1'b0, 5'b00100, 8'h00);
    op(1'b0, 5'b00001, 8'h00);
    check("t2.r", 32'(r0), 32'h05);

    // Positive overflow on add, then negative-minus-positive overflow on sub
    op(1'b1, 5'b00000, 8'h00);
    op(1'b0, 5'b10000, 8'h7F);
    op(1'b0, 5'b00100, 8'h00);
    op(1'b0, 5'b10000, 8'h01);
    op(1'b0, 5'b00101, 8'h00);
    check("t3a.v", 32'(v0), 32'h1);
    op(1'b0, 5'b01001, 8'h00);
    check("t3b.r", 32'(r0), 32'h80);

    // Zero result, then LDR without FLG keeps Z
    op(1'b1, 5'b00000, 8'h00);
    op(1'b0, 5'b10000, 8'h05);
    op(1'b0, 5'b00100, 8'h00);
    op(1'b0, 5'b01101, 8'h00);
    op(1'b0, 5'b00100, 8'h00);
    check("t4.z_hold", 32'(z0), 32'h1);

    // Same-cycle LDA+LDR uses old A
    op(1'b1, 5'b00000, 8'h00);
    op(1'b0, 5'b10000, 8'h01);
    op(1'b0, 5'b00100, 8'h00);
    op(1'b0, 5'b10000, 8'h05);
    op(1'b0, 5'b10100, 8'h09);
    check("t5.r", 32'(r0), 32'h06);
    op(1'b0, 5'b00100, 8'h00);
    check("t5.a_new", 32'(r0), 32'h0F);

    // Counter wrap on both instances, then start during INC
    step(1'b1, 5'b00000, 8'h00, 1'b1, 5'b00000, 8'h00);
    for (int i = 0; i < 16; i++)
      step(1'b0, 5'b00010, 8'h00, 1'b0, 5'b00010, 8'h00);
    step(1'b0, 5'b00000, 8'h00, 1'b0, 5'b00010, 8'h00);
    step(1'b0, 5'b00010, 8'h00, 1'b1, 5'b00010, 8'h00);
    check("t6.start_c", 32'(c1), 32'h0);
    for (int i = 0; i < 7; i++)
      step(1'b0, 5'b00000, 8'h00, 1'b0, 5'b00010, 8'h00);
    step(1'b0, 5'b00000, 8'h00, 1'b1, 5'b00010, 8'h00);
    check("t6.start_wrap", 32'(wrap1), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) == 0), 5'($urandom), 8'($urandom),
           ($urandom_range(0, 15) == 0), 5'($urandom), 8'($urandom));
      if (i % 60 == 59)
        async_clear();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
